// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - Bus command codes driven on proc2Dmem_command.
//   - wb_entry_t: one write-buffer slot (word index + store data). The index
//     field is sized by MAX_AW, wide enough for any word index of a 32-bit
//     byte address; instances zero-extend their AW-bit index into it.
package dmem_pkg;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  localparam int MAX_AW = 30;

  typedef struct packed {
    logic [MAX_AW-1:0] idx;
    logic [31:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/dmem_if.sv
// dmem_if: MEM-stage bus between the processor (master) and the responder
// (slave).
//   proc2Dmem_command  2   BUS_NONE / BUS_LOAD / BUS_STORE (3 acts as NONE)
//   proc2Dmem_addr     32  byte address
//   proc2mem_data      32  store data
//   mem2proc_data      32  load data, valid in the same cycle as the load
interface dmem_if;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2Dmem_addr;
  logic [31:0] proc2mem_data;
  logic [31:0] mem2proc_data;

  modport master (
    output proc2Dmem_command, proc2Dmem_addr, proc2mem_data,
    input  mem2proc_data
  );

  modport slave (
    input  proc2Dmem_command, proc2Dmem_addr, proc2mem_data,
    output mem2proc_data
  );
endinterface

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: circular store buffer with youngest-match lookup.
//   clk, rst     clock, synchronous active-high reset (empties the buffer)
//   push         enqueue push_entry at the tail
//   pop          drop the head entry (head_entry shows it beforehand)
//   head_entry   oldest valid entry
//   count        number of valid entries, 0..DEPTH
//   lookup_idx   word index to search for
//   hit/hit_data youngest valid entry with a matching index
// Push and pop on the same edge are allowed even when full: the slot being
// written is the one being released.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output wb_entry_t              head_entry,
  output logic [$clog2(DEPTH):0] count,
  input  logic [MAX_AW-1:0]      lookup_idx,
  output logic                   hit,
  output logic [31:0]            hit_data
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t     slots [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] slot_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity comes from head/count only.
  always_ff @(posedge clk) begin
    if (!rst && push) slots[tail] <= push_entry;
  end

  assign head_entry = slots[head];

  // Walk oldest to youngest so the last match (the youngest) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot_p   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_p = head + PW'(i);
      if (((PW+1)'(i) < count) && (slots[slot_p].idx == lookup_idx)) begin
        hit      = 1'b1;
        hit_data = slots[slot_p].data;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: zero-latency data memory for the MEM stage.
//   clk, rst        clock, synchronous active-high reset
//   bus (slave)     proc2Dmem_* command/address/data in, mem2proc_data out
//   wb_count        valid write-buffer entries
//   wb_empty        wb_count == 0
//   stat_loads, stat_stores, stat_fwd_hits (only with DMEM_STATS_EN defined)
// Loads read combinationally, forwarding from the write buffer first. Stores
// are posted to the buffer; the head drains into the single-ported array on
// every non-load edge, so a store edge with a non-empty buffer both drains and
// enqueues and the buffer cannot overflow.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int WB_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  dmem_if.slave                     bus,
  output logic [$clog2(WB_DEPTH):0] wb_count,
  output logic                      wb_empty
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]               stat_loads,
  output logic [31:0]               stat_stores,
  output logic [31:0]               stat_fwd_hits
`endif
);
  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   mem [MEM_WORDS];
  logic [AW-1:0] word_idx;
  logic          is_load;
  logic          is_store;
  logic          drain;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  wb_entry_t     push_entry;
  wb_entry_t     head_entry;

  // Commands are ignored while rst is high.
  assign word_idx = bus.proc2Dmem_addr[AW+1:2];
  assign is_load  = !rst && (bus.proc2Dmem_command == BUS_LOAD);
  assign is_store = !rst && (bus.proc2Dmem_command == BUS_STORE);
  assign drain    = !rst && (bus.proc2Dmem_command != BUS_LOAD) && (wb_count != '0);

  assign push_entry = '{idx: MAX_AW'(word_idx), data: bus.proc2mem_data};

  dmem_wbuf #(.DEPTH(WB_DEPTH)) u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .push       (is_store),
    .push_entry (push_entry),
    .pop        (drain),
    .head_entry (head_entry),
    .count      (wb_count),
    .lookup_idx (MAX_AW'(word_idx)),
    .hit        (fwd_hit),
    .hit_data   (fwd_data)
  );

  assign wb_empty = (wb_count == '0);

  // Array keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (drain) mem[head_entry.idx[AW-1:0]] <= head_entry.data;
  end

  assign bus.mem2proc_data = !is_load ? 32'h0 :
                             fwd_hit  ? fwd_data : mem[word_idx];

  logic unused_bits;
  assign unused_bits = ^{bus.proc2Dmem_addr[31:AW+2], bus.proc2Dmem_addr[1:0],
                         head_entry.idx[MAX_AW-1:AW]};

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads    <= '0;
      stat_stores   <= '0;
      stat_fwd_hits <= '0;
    end else begin
      if (is_load)            stat_loads    <= stat_loads + 32'd1;
      if (is_store)           stat_stores   <= stat_stores + 32'd1;
      if (is_load && fwd_hit) stat_fwd_hits <= stat_fwd_hits + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import dmem_pkg::*;

  logic       clk;
  logic       rst;
  logic [2:0] wb_count;
  logic       wb_empty;
`ifdef DMEM_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_fwd_hits;
`endif

  dmem_if bus_if ();

  dmem_responder #(.MEM_WORDS(1024), .WB_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if.slave),
    .wb_count (wb_count),
    .wb_empty (wb_empty)
`ifdef DMEM_STATS_EN
    ,
    .stat_loads    (stat_loads),
    .stat_stores   (stat_stores),
    .stat_fwd_hits (stat_fwd_hits)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory = committed words + FIFO of posted stores.
  typedef struct {
    int          idx;
    logic [31:0] data;
  } st_t;

  typedef struct {
    logic [31:0] data;
    int          cnt;
    int unsigned sl, ss, sf;
  } exp_t;

  logic [31:0] committed [int];
  st_t         pend [$];
  exp_t        exp_q [$];
  int unsigned m_loads, m_stores, m_fwd;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit known(input int idx);
    if (committed.exists(idx)) return 1'b1;
    foreach (pend[i]) if (pend[i].idx == idx) return 1'b1;
    return 1'b0;
  endfunction

  // Issue one cycle of stimulus, record the expected response, then advance
  // the model across the clock edge.
  task automatic op(input logic [1:0] cmd, input logic [31:0] addr,
                    input logic [31:0] data, input logic do_rst);
    exp_t e;
    int   idx;
    bit   hit;
    idx = int'(addr[11:2]);
    rst = do_rst;
    bus_if.proc2Dmem_command = cmd;
    bus_if.proc2Dmem_addr    = addr;
    bus_if.proc2mem_data     = data;
    e.cnt  = pend.size();
    e.sl   = m_loads;
    e.ss   = m_stores;
    e.sf   = m_fwd;
    e.data = 32'h0;
    hit    = 1'b0;
    if (!do_rst && cmd == BUS_LOAD) begin
      for (int i = pend.size() - 1; i >= 0; i--) begin
        if (pend[i].idx == idx) begin
          e.data = pend[i].data;
          hit    = 1'b1;
          break;
        end
      end
      if (!hit) e.data = committed[idx];
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (do_rst) begin
      pend.delete();
      m_loads = 0; m_stores = 0; m_fwd = 0;
    end else if (cmd == BUS_LOAD) begin
      m_loads++;
      if (hit) m_fwd++;
    end else begin
      if (pend.size() > 0) begin
        committed[pend[0].idx] = pend[0].data;
        void'(pend.pop_front());
      end
      if (cmd == BUS_STORE) begin
        pend.push_back('{idx: idx, data: data});
        m_stores++;
      end
    end
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d);
    op(BUS_STORE, a, d, 1'b0);
  endtask
  task automatic ld(input logic [31:0] a);
    op(BUS_LOAD, a, $urandom, 1'b0);
  endtask
  task automatic idle();
    op(BUS_NONE, $urandom, $urandom, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents load data and buffer status.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("mem2proc_data", bus_if.mem2proc_data, e.data);
      chk("wb_count", 32'(wb_count), e.cnt);
      chk("wb_empty", 32'(wb_empty), 32'(e.cnt == 0));
`ifdef DMEM_STATS_EN
      chk("stat_loads", stat_loads, e.sl);
      chk("stat_stores", stat_stores, e.ss);
      chk("stat_fwd_hits", stat_fwd_hits, e.sf);
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    m_loads = 0; m_stores = 0; m_fwd = 0;
    rst = 1'b1;
    bus_if.proc2Dmem_command = BUS_NONE;
    bus_if.proc2Dmem_addr    = '0;
    bus_if.proc2mem_data     = '0;
    @(posedge clk); #1;
    op(BUS_LOAD, 32'h100, 32'h0, 1'b1);

    // Forwarding from the buffer immediately after a store.
    st(32'h100, 32'hDEADBEEF);
    ld(32'h100);
    // Drained store served from the array.
    st(32'h10, 32'h1);
    idle(); idle(); idle();
    ld(32'h10);
    // Back-to-back stores drain and enqueue each edge.
    for (int i = 0; i < 6; i++) st(32'(i * 4), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 6; i++) ld(32'(i * 4));
    // Store/load interleave, then one extra store.
    for (int i = 0; i < 4; i++) begin
      st(32'h200 + 32'(i * 4), 32'hB000_0000 + 32'(i));
      ld(32'h200 + 32'(i * 4));
    end
    st(32'h210, 32'hB000_0004);
    for (int i = 0; i < 5; i++) ld(32'h200 + 32'(i * 4));
    // Same index stored twice: youngest wins, both forwarded and drained.
    st(32'h20, 32'hA);
    st(32'h20, 32'hB);
    ld(32'h20);
    idle(); idle();
    ld(32'h20);
    // Reset discards buffered store, keeps drained array word.
    st(32'h44, 32'h4444_0044);
    idle();
    st(32'h40, 32'h7);
    ld(32'h40);
    op(BUS_LOAD, 32'h40, 32'h0, 1'b1);
    idle();
    ld(32'h44);
    // Ignored address bits and command code 3.
    st(32'hFFFF_F04B, 32'h1234_5678);
    op(2'd3, 32'h0, 32'h0, 1'b0);
    ld(32'h0000_0048);

    // Randomized traffic over a small index range to force buffer hits.
    for (int n = 0; n < 1500; n++) begin
      int          r;
      int          idx;
      logic [31:0] a;
      r   = $urandom_range(0, 99);
      idx = $urandom_range(0, 15);
      a   = ($urandom & ~32'h0000_0FFC) | (32'(idx) << 2);
      if (r < 3)                     op(2'($urandom_range(0, 3)), a, $urandom, 1'b1);
      else if (r < 40)               st(a, $urandom);
      else if (r < 75 && known(idx)) ld(a);
      else if (r < 85)               op(2'd3, a, $urandom, 1'b0);
      else                           idle();
    end
    idle(); idle();
    @(negedge clk); @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
